// File: rtl/rv32i_core.sv
// Single-cycle RV32I core with a unified word-addressed memory and a 32-entry register file.
// Fetch, decode, execute, load and writeback all settle combinationally; the PC, rd and stores commit on the rising edge.
module rv32i_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] data [0:31];

    // data[0] is cleared by reset and never written, so x0 always reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) data[i] <= '0;
        end else if (we_i && waddr_i != 5'd0) begin
            data[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = data[raddr1_i];
    assign rdata2_o = data[raddr2_i];
endmodule

module rv32i_core #(
    parameter int MEM_WORDS = 16384
) (
    input  logic clk,
    input  logic rst_n
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                           OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13,
                           OP_OP = 7'h33, OP_SYS = 7'h73;

    logic [31:0] mem [0:MEM_WORDS-1];
    logic [31:0] pc_q, pc_d, instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, op_b, alu_res, mem_addr, ld_word, ld_val;
    logic [31:0] rd_wdata, st_data;
    logic [3:0]  st_be;
    logic [4:0]  shamt;
    logic        rd_we, st_en, take, alt, is_ecall, unused_bits;

    assign instr    = mem[pc_q[AW+1:2]];
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_ecall = (instr == 32'h0000_0073);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    rv32i_regfile i_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (rd_we),
        .waddr_i  (instr[11:7]),
        .wdata_i  (rd_wdata),
        .raddr1_i (instr[19:15]),
        .raddr2_i (instr[24:20]),
        .rdata1_o (rs1_val),
        .rdata2_o (rs2_val)
    );

    assign mem_addr    = rs1_val + ((opcode == OP_ST) ? imm_s : imm_i);
    assign ld_word     = mem[mem_addr[AW+1:2]];
    assign unused_bits = ^mem_addr[31:AW+2];

    // funct7[5] selects SUB only for register ops; for shifts it selects SRA/SRAI
    assign op_b  = (opcode == OP_OP) ? rs2_val : imm_i;
    assign shamt = op_b[4:0];
    assign alt   = instr[30] & ((opcode == OP_OP) | (funct3 == 3'b101));

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = alt ? rs1_val - op_b : rs1_val + op_b;
            3'b001: alu_res = rs1_val << shamt;
            3'b010: alu_res = {31'b0, $signed(rs1_val) < $signed(op_b)};
            3'b011: alu_res = {31'b0, rs1_val < op_b};
            3'b100: alu_res = rs1_val ^ op_b;
            3'b101: begin
                if (alt) alu_res = $signed(rs1_val) >>> shamt;
                else     alu_res = rs1_val >> shamt;
            end
            3'b110: alu_res = rs1_val | op_b;
            default: alu_res = rs1_val & op_b;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000: take = (rs1_val == rs2_val);
            3'b001: take = (rs1_val != rs2_val);
            3'b100: take = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101: take = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: take = (rs1_val <  rs2_val);
            3'b111: take = (rs1_val >= rs2_val);
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        logic [7:0]  lb;
        logic [15:0] lh;
        lb = '0;
        case (mem_addr[1:0])
            2'd0: lb = ld_word[7:0];
            2'd1: lb = ld_word[15:8];
            2'd2: lb = ld_word[23:16];
            default: lb = ld_word[31:24];
        endcase
        lh = mem_addr[1] ? ld_word[31:16] : ld_word[15:0];
        case (funct3)
            3'b000: ld_val = {{24{lb[7]}}, lb};
            3'b001: ld_val = {{16{lh[15]}}, lh};
            3'b100: ld_val = {24'b0, lb};
            3'b101: ld_val = {16'b0, lh};
            default: ld_val = ld_word;
        endcase
    end

    // Stores replicate the source across lanes; byte enables pick which lanes land
    always_comb begin
        st_data = rs2_val;
        st_be   = 4'b1111;
        case (funct3)
            3'b000: begin
                st_data = {4{rs2_val[7:0]}};
                st_be   = 4'b0001 << mem_addr[1:0];
            end
            3'b001: begin
                st_data = {2{rs2_val[15:0]}};
                st_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_d     = pc_q + 32'd4;
        rd_we    = 1'b0;
        rd_wdata = alu_res;
        st_en    = 1'b0;
        case (opcode)
            OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
            OP_AUIPC: begin rd_we = 1'b1; rd_wdata = pc_q + imm_u; end
            OP_JAL:   begin rd_we = 1'b1; rd_wdata = pc_q + 32'd4; pc_d = pc_q + imm_j; end
            OP_JALR:  begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + 32'd4;
                pc_d     = (rs1_val + imm_i) & 32'hFFFF_FFFE;
            end
            OP_BR:    if (take) pc_d = pc_q + imm_b;
            OP_LD:    begin
                rd_we    = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
                rd_wdata = ld_val;
            end
            OP_ST:    st_en = (funct3[2] == 1'b0) && (funct3 != 3'b011);
            OP_IMM, OP_OP: rd_we = 1'b1;
            OP_SYS:   begin
                if (is_ecall) pc_d = pc_q;
                else if (funct3 != 3'b000) begin
                    rd_we    = 1'b1;
                    rd_wdata = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    // Memory has no reset so a preloaded image survives; reset only gates the write
    always_ff @(posedge clk) begin
        if (rst_n && st_en) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) mem[mem_addr[AW+1:2]][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_rv32i_core.sv
// Directed programs for rv32i_core, checked every cycle against an instruction-level interpreter.
module tb_rv32i_core;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rv32i_core dut (.clk(clk), .rst_n(rst_n));

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mb [0:65535];
    logic [31:0] mx [0:31];
    logic [31:0] mpc = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd32(input logic [31:0] a);
        logic [15:0] e;
        e = {a[15:2], 2'b00};
        return {mb[e+16'd3], mb[e+16'd2], mb[e+16'd1], mb[e]};
    endfunction

    // Instruction encoders
    function automatic logic [31:0] e_i(input int op, input int f3, input int rd, input int rs1, input int imm);
        logic [31:0] o, f, d, s, m;
        o = op; f = f3; d = rd; s = rs1; m = imm;
        return {m[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] e_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
        logic [31:0] g, f, d, s, t;
        g = f7; f = f3; d = rd; s = rs1; t = rs2;
        return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] e_s(input int f3, input int rs2, input int rs1, input int imm);
        logic [31:0] f, s, t, m;
        f = f3; s = rs1; t = rs2; m = imm;
        return {m[11:5], t[4:0], s[4:0], f[2:0], m[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_b(input int f3, input int rs1, input int rs2, input int imm);
        logic [31:0] f, s, t, m;
        f = f3; s = rs1; t = rs2; m = imm;
        return {m[12], m[10:5], t[4:0], s[4:0], f[2:0], m[4:1], m[11], 7'h63};
    endfunction
    function automatic logic [31:0] e_u(input int op, input int rd, input int imm20);
        logic [31:0] o, d, m;
        o = op; d = rd; m = imm20;
        return {m[19:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] e_j(input int rd, input int imm);
        logic [31:0] d, m;
        d = rd; m = imm;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6f};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return e_i('h13, 0, rd, rs1, imm);
    endfunction

    // Reference interpreter: one architectural instruction per call, byte-addressed memory
    task automatic model_step();
        logic [31:0] i, a, b, y, iimm, simm, bimm, jimm, uimm, ea, val, nxt;
        logic [15:0] e;
        logic [2:0]  f3;
        logic        wr, tk;
        i = rd32(mpc);
        f3 = i[14:12];
        a = mx[i[19:15]];
        b = mx[i[24:20]];
        iimm = {{20{i[31]}}, i[31:20]};
        simm = {{20{i[31]}}, i[31:25], i[11:7]};
        bimm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        jimm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        uimm = {i[31:12], 12'h000};
        nxt = mpc + 32'd4;
        wr = 1'b0;
        val = '0;
        tk = 1'b0;
        case (i[6:0])
            7'h37: begin wr = 1'b1; val = uimm; end
            7'h17: begin wr = 1'b1; val = mpc + uimm; end
            7'h6f: begin wr = 1'b1; val = mpc + 32'd4; nxt = mpc + jimm; end
            7'h67: begin wr = 1'b1; val = mpc + 32'd4; nxt = (a + iimm) & 32'hFFFF_FFFE; end
            7'h63: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                if (tk) nxt = mpc + bimm;
            end
            7'h03: begin
                ea = a + iimm;
                e = ea[15:0];
                wr = 1'b1;
                case (f3)
                    3'd0: val = {{24{mb[e][7]}}, mb[e]};
                    3'd1: begin e[0] = 1'b0; val = {{16{mb[e+16'd1][7]}}, mb[e+16'd1], mb[e]}; end
                    3'd2: val = rd32(ea);
                    3'd4: val = {24'b0, mb[e]};
                    3'd5: begin e[0] = 1'b0; val = {16'b0, mb[e+16'd1], mb[e]}; end
                    default: wr = 1'b0;
                endcase
            end
            7'h23: begin
                ea = a + simm;
                e = ea[15:0];
                case (f3)
                    3'd0: mb[e] = b[7:0];
                    3'd1: begin e[0] = 1'b0; mb[e] = b[7:0]; mb[e+16'd1] = b[15:8]; end
                    3'd2: begin
                        e[1:0] = 2'b00;
                        mb[e] = b[7:0]; mb[e+16'd1] = b[15:8];
                        mb[e+16'd2] = b[23:16]; mb[e+16'd3] = b[31:24];
                    end
                    default: ;
                endcase
            end
            7'h13, 7'h33: begin
                y = (i[6:0] == 7'h33) ? b : iimm;
                wr = 1'b1;
                case (f3)
                    3'd0: val = (i[5] && i[30]) ? a - y : a + y;
                    3'd1: val = a << y[4:0];
                    3'd2: val = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                    3'd3: val = (a < y) ? 32'd1 : 32'd0;
                    3'd4: val = a ^ y;
                    3'd5: begin
                        if (i[30]) val = $signed(a) >>> y[4:0];
                        else       val = a >> y[4:0];
                    end
                    3'd6: val = a | y;
                    default: val = a & y;
                endcase
            end
            7'h73: begin
                if (i == 32'h0000_0073) nxt = mpc;
                else if (f3 != 3'd0) begin wr = 1'b1; val = '0; end
            end
            default: ;
        endcase
        if (wr && i[11:7] != 5'd0) mx[i[11:7]] = val;
        mpc = nxt;
    endtask

    always @(posedge clk) if (rst_n) model_step();

    // Per-cycle comparison of architectural state
    always @(negedge clk) begin
        int idx;
        idx = 0;
        for (int r = 31; r >= 0; r--) if (dut.i_regfile.data[r] !== mx[r]) idx = r;
        chk("pc", dut.pc_q, mpc);
        chk($sformatf("x%0d", idx), dut.i_regfile.data[idx], mx[idx]);
        chk("is_ecall", {31'b0, dut.is_ecall}, {31'b0, rd32(mpc) == 32'h0000_0073});
    end

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        mpc = '0;
        for (int r = 0; r < 32; r++) mx[r] = '0;
    endtask

    task automatic load(input logic [31:0] p[$]);
        for (int w = 0; w < 128; w++) begin
            dut.mem[w] = '0;
            for (int k = 0; k < 4; k++) mb[w*4+k] = 8'h00;
        end
        foreach (p[w]) begin
            dut.mem[w] = p[w];
            for (int k = 0; k < 4; k++) mb[w*4+k] = p[w][8*k +: 8];
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ecall(input int budget);
        int c;
        c = 0;
        while (!dut.is_ecall && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (!dut.is_ecall) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ecall_timeout: got no ECALL expected ECALL within %0d cycles", budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_mem();
        int idx;
        idx = 60;
        for (int w = 70; w >= 60; w--) if (dut.mem[w] !== rd32(w*4)) idx = w;
        chk($sformatf("mem[%0d]", idx), dut.mem[idx], rd32(idx*4));
    endtask

    function automatic logic [31:0] rf(input int r);
        return dut.i_regfile.data[r];
    endfunction

    logic [31:0] p2[$];

    initial begin
        logic [31:0] p[$];
        #1;
        // ADDI then ECALL: halts at pc 4 within two cycles
        do_reset();
        p = '{addi(3, 0, 1), 32'h0000_0073};
        load(p);
        chk("reset_pc", dut.pc_q, 32'h0);
        release_rst();
        wait_ecall(2);
        chk("p1_x3", rf(3), 32'h1);
        chk("p1_pc", dut.pc_q, 32'h4);

        // Loads and stores across lanes
        do_reset();
        p2 = '{e_u('h37, 5, 'h12345), addi(5, 5, 'h678), e_s(2, 5, 0, 256),
               e_i('h03, 0, 6, 0, 257), e_i('h03, 5, 7, 0, 258), e_s(1, 5, 0, 262),
               e_s(0, 5, 0, 261), e_i('h03, 2, 8, 0, 260), e_i('h03, 1, 9, 0, 262),
               addi(10, 0, -128), e_s(0, 10, 0, 264), e_i('h03, 0, 11, 0, 264),
               e_i('h03, 4, 12, 0, 264), e_s(1, 10, 0, 266), e_i('h03, 1, 13, 0, 266),
               32'h0000_0073};
        load(p2);
        release_rst();
        wait_ecall(40);
        chk("p2_x5", rf(5), 32'h1234_5678);
        chk("p2_x6", rf(6), 32'h0000_0056);
        chk("p2_x7", rf(7), 32'h0000_1234);
        chk("p2_x8", rf(8), 32'h5678_7800);
        chk("p2_x11", rf(11), 32'hFFFF_FF80);
        chk("p2_x12", rf(12), 32'h0000_0080);
        chk("p2_x13", rf(13), 32'hFFFF_FF80);
        chk("p2_mem66", dut.mem[66], 32'hFF80_0080);
        chk_mem();

        // ALU, shifts and compares
        do_reset();
        p = '{addi(1, 0, -1), e_i('h13, 5, 2, 1, 'h404), e_i('h13, 5, 3, 1, 28),
              e_r(0, 3, 4, 0, 1), e_r(0, 2, 5, 1, 0), addi(6, 0, 5), e_r(0, 1, 7, 6, 6),
              e_r('h20, 0, 8, 0, 6), e_r('h20, 5, 9, 8, 6), e_r(0, 5, 10, 8, 6),
              e_r(0, 4, 11, 6, 1), e_r(0, 6, 12, 6, 7), e_r(0, 7, 13, 1, 7),
              e_i('h13, 2, 14, 8, -4), e_i('h13, 3, 15, 6, -1), e_i('h13, 4, 16, 6, 'hFF),
              e_i('h13, 6, 17, 6, -16), e_i('h13, 7, 18, 1, 'hF0), e_i('h13, 1, 19, 6, 30),
              e_u('h17, 20, 1), e_r(0, 0, 21, 1, 1), 32'h0000_0073};
        load(p);
        release_rst();
        wait_ecall(40);
        chk("p3_x2", rf(2), 32'hFFFF_FFFF);
        chk("p3_x3", rf(3), 32'h0000_000F);
        chk("p3_x4", rf(4), 32'h1);
        chk("p3_x5", rf(5), 32'h1);
        chk("p3_x10", rf(10), 32'h07FF_FFFF);
        chk("p3_x19", rf(19), 32'h4000_0000);
        chk("p3_x20", rf(20), 32'h0000_104C);

        // BNE skip, JAL link, JALR return
        do_reset();
        p = '{addi(2, 0, 1), e_b(1, 2, 0, 8), addi(3, 0, 7), addi(4, 0, 2),
              e_j(1, 12), 32'h0000_0073, addi(5, 0, 9), e_i('h67, 0, 0, 1, 0)};
        load(p);
        release_rst();
        repeat (4) @(negedge clk);
        chk("p4_jal_pc", dut.pc_q, 32'h0000_001C);
        chk("p4_x1", rf(1), 32'h0000_0014);
        wait_ecall(10);
        chk("p4_ret_pc", dut.pc_q, 32'h0000_0014);
        chk("p4_x3", rf(3), 32'h0);
        chk("p4_x5", rf(5), 32'h0);

        // x0 is hardwired
        do_reset();
        p = '{addi(0, 0, 5), e_r(0, 0, 3, 0, 0), 32'h0000_0073};
        load(p);
        release_rst();
        wait_ecall(10);
        chk("p5_x0", rf(0), 32'h0);
        chk("p5_x3", rf(3), 32'h0);

        // Remaining branches, CSR, NOP-class and unknown opcodes
        do_reset();
        p = '{addi(1, 0, -2), addi(2, 0, 3), e_b(4, 1, 2, 8), addi(3, 0, 1),
              e_b(5, 1, 2, 8), addi(4, 0, 1), e_b(6, 1, 2, 8), addi(5, 0, 1),
              e_b(7, 1, 2, 8), addi(6, 0, 1), e_b(0, 2, 2, 8), addi(7, 0, 1),
              addi(8, 0, 5), e_i('h73, 2, 8, 0, 'h300), 32'h0FF0_000F, 32'h0010_0073,
              32'hFFFF_FFFF, 32'h1050_0073, 32'h3020_0073, e_b(0, 1, 2, 8),
              addi(9, 0, 9), 32'h0000_0073};
        load(p);
        release_rst();
        wait_ecall(40);
        chk("p6_pc", dut.pc_q, 32'h0000_0054);
        chk("p6_x3", rf(3), 32'h0);
        chk("p6_x4", rf(4), 32'h1);
        chk("p6_x5", rf(5), 32'h1);
        chk("p6_x6", rf(6), 32'h0);
        chk("p6_x7", rf(7), 32'h0);
        chk("p6_x8", rf(8), 32'h0);
        chk("p6_x9", rf(9), 32'h9);

        // Asynchronous reset mid-program, then re-run
        do_reset();
        load(p2);
        release_rst();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        mpc = '0;
        for (int r = 0; r < 32; r++) mx[r] = '0;
        #1;
        chk("async_pc", dut.pc_q, 32'h0);
        chk("async_x5", rf(5), 32'h0);
        chk("async_mem64", dut.mem[64], 32'h1234_5678);
        release_rst();
        wait_ecall(40);
        chk("rerun_x5", rf(5), 32'h1234_5678);
        chk("rerun_x7", rf(7), 32'h0000_1234);
        chk_mem();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv32i_core.md
RV32I_CORE -- requirements
Module: rv32i_core

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 16384, giving the number of 32-bit words in the unified instruction/data memory (64 KiB).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have no other ports; the core is self-contained, and test results are read hierarchically.
REQ-005 SHALL contain a memory array named mem, 32-bit words, indices 0..MEM_WORDS-1, loadable by $readmemh; word index = byte address[15:2], upper address bits ignored (aliasing).
REQ-006 SHALL contain a register-file instance named i_regfile holding array data[0:31] of 32-bit registers, so that data[3] is x3/gp.
REQ-007 SHALL expose an internal 1-bit signal is_ecall, high while the instruction at the current PC is ECALL (0x00000073).

Function
REQ-008 SHALL be a single-cycle, non-pipelined RV32I core: fetch, decode, execute, memory and writeback complete in one clock; one instruction retires per cycle.
REQ-009 SHALL fetch combinationally: instr = mem[pc[15:2]].
REQ-010 SHALL implement all RV32I base instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
REQ-011 SHALL compute all arithmetic modulo 2^32; shifts use rs2/imm[4:0]; SRA/SRAI sign-fill; SLT signed, SLTU unsigned.
REQ-012 SHALL sign-extend immediates per the I/S/B/U/J formats; branch/JAL targets = pc + imm; JALR target = (rs1 + imm) with bit 0 cleared; link value = pc + 4.
REQ-013 SHALL hardwire x0: reads return 0, writes are discarded.
REQ-014 SHALL read rs1/rs2 combinationally and write rd on the rising clk edge.
REQ-015 SHALL perform loads combinationally from mem; byte lane = addr[1:0], halfword lane = addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; word accesses ignore addr[1:0].
REQ-016 SHALL perform stores on the rising clk edge, modifying only the addressed byte lanes (SB: one byte, SH: two bytes, SW: all four).
REQ-017 SHALL make a load in the cycle after a store to the same address return the stored data.
REQ-018 SHALL execute FENCE, FENCE.I, EBREAK, MRET and WFI as NOPs (pc + 4).
REQ-019 SHALL treat CSR instructions (opcode 1110011, funct3 != 0) as writing 0 to rd with no other effect.
REQ-020 SHALL halt on ECALL: while is_ecall is high the PC holds, and no register or memory write occurs.
REQ-021 SHALL treat unrecognised opcodes as NOPs (pc + 4, no writes).
REQ-022 SHALL assume naturally aligned accesses; misaligned halfword/word accesses and misaligned jump targets raise no exception, and the resulting data is unspecified.

Reset
REQ-023 SHALL, while rst_n = 0, force pc = 0x00000000 and x1..x31 = 0, and suppress all register and memory writes.
REQ-024 SHALL leave mem unaffected by reset, so that a preloaded image survives.
REQ-025 SHALL fetch from address 0 on the first rising edge after rst_n deasserts; asserting rst_n mid-program restarts execution from pc 0.

Verification
REQ-026 SHALL pass this scenario: mem[0]=ADDI x3,x0,1; mem[1]=ECALL; release reset -> within 2 cycles is_ecall=1, data[3]=1, and pc stays at 4.
REQ-027 SHALL pass this scenario: LUI x5,0x12345; ADDI x5,x5,0x678; SW x5,256(x0); LB x6,257(x0); LHU x7,258(x0) -> x5=0x12345678, x6=0x00000056, x7=0x00001234.
REQ-028 SHALL pass this scenario: ADDI x1,x0,-1; SRAI x2,x1,4; SRLI x3,x1,28; SLTU x4,x0,x1; SLT x5,x1,x0 -> x2=0xFFFFFFFF, x3=0xF, x4=1, x5=1.
REQ-029 SHALL pass this scenario: BNE taken to +8 skips one instruction; JAL x1,+12 at pc 0x10 gives x1=0x14 and pc=0x1C; JALR x0,0(x1) returns to 0x14.
REQ-030 SHALL pass this scenario: ADDI x0,x0,5 then ADD x3,x0,x0 -> x0 reads 0 and x3=0.
REQ-031 SHALL pass this scenario: assert rst_n=0 asynchronously mid-program, then release -> pc=0, x1..x31=0, mem unchanged, and the program re-runs to the same ECALL result.
